// File: rtl/iiitb_sd_serializer.sv
// -----------------------------------------------------------------------------
// iiitb_sd_serializer
//
// Parallel-to-serial front end for the sequence detector. WIDTH-bit words are
// accepted over a valid/ready handshake and shifted out one bit per clock on
// sequence_out. The next word can be accepted on the last-bit edge, so
// back-to-back words stream with no bubble. While idle the line sits at 0.
//
// Handshake: a word transfers on a rising edge where data_valid && data_ready.
// data_ready depends only on reset, state and cnt (never on data_valid), so a
// producer may drive data_valid from data_ready without forming a loop.
//
// Parameters:
//   WIDTH      bits per word, 2..32
//   MSB_FIRST  1: bit WIDTH-1 is sent first; 0: bit 0 is sent first
//
// Ports:
//   clock         rising-edge clock
//   reset         synchronous, active-high reset
//   data_in       parallel word to serialize
//   data_valid    data_in is valid this cycle
//   data_ready    block accepts data_in this cycle (0 while reset is high)
//   sequence_out  serial bit stream (registered), 0 when idle
//   bit_valid     sequence_out carries a payload bit
//   busy          FSM is in SHIFT (exposes the state for checkers)
//   words_sent    count of fully transmitted words, wraps at 16 bits
// -----------------------------------------------------------------------------
module iiitb_sd_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             sequence_out,
    output logic             bit_valid,
    output logic             busy,
    output logic [15:0]      words_sent
);

    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    cnt;
    logic [15:0]      words_q;
    logic             last_bit;
    logic             accept;

    assign last_bit = (state == SHIFT) && (cnt == LAST);
    assign accept   = data_valid && data_ready;

    // ---------------------------------------------------------------- state
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                // On the last bit either reload (stay) or fall back to idle.
                if (last_bit && !accept) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        data_ready = 1'b0;
        bit_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                data_ready = !reset;
            end
            SHIFT: begin
                data_ready = !reset && (cnt == LAST);
                bit_valid  = 1'b1;
                busy       = 1'b1;
            end
            default: begin
                data_ready = 1'b0;
            end
        endcase
    end

    // The output end of sreg is the serial line itself. Zeros are shifted in
    // behind the payload, so after the final shift sreg is all zero and the
    // line idles at 0 without any extra gating.
    assign sequence_out = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
    assign words_sent   = words_q;

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clock) begin
        if (reset) begin
            sreg    <= '0;
            cnt     <= '0;
            words_q <= '0;
        end else begin
            if (accept) begin
                sreg <= data_in;
                cnt  <= '0;
            end else if (state == SHIFT) begin
                if (MSB_FIRST) begin
                    sreg <= {sreg[WIDTH-2:0], 1'b0};
                end else begin
                    sreg <= {1'b0, sreg[WIDTH-1:1]};
                end
                cnt <= last_bit ? '0 : cnt + CW'(1);
            end
            if (last_bit) begin
                words_q <= words_q + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_iiitb_sd_serializer.sv
// -----------------------------------------------------------------------------
// tb_iiitb_sd_serializer
//
// Two serializers (MSB-first and LSB-first, WIDTH=8) share the same inputs;
// both have identical handshake timing, so every directed step exercises
// both bit orders. Expected bits are pushed to per-instance queues at the
// accepting edge and popped by a negedge monitor whenever bit_valid is high.
// -----------------------------------------------------------------------------
module tb_iiitb_sd_serializer;

  localparam int W = 8;

  logic         clock;
  logic         reset;
  logic [W-1:0] data_in;
  logic         data_valid;

  logic         ready_m, seq_m, bv_m, busy_m;
  logic [15:0]  words_m;
  logic         ready_l, seq_l, bv_l, busy_l;
  logic [15:0]  words_l;

  logic [W-1:0] exp_m[$];
  logic [W-1:0] exp_l[$];

  int n_vec;
  int n_err;
  bit mon_en;

  iiitb_sd_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clock        (clock),
    .reset        (reset),
    .data_in      (data_in),
    .data_valid   (data_valid),
    .data_ready   (ready_m),
    .sequence_out (seq_m),
    .bit_valid    (bv_m),
    .busy         (busy_m),
    .words_sent   (words_m)
  );

  iiitb_sd_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clock        (clock),
    .reset        (reset),
    .data_in      (data_in),
    .data_valid   (data_valid),
    .data_ready   (ready_l),
    .sequence_out (seq_l),
    .bit_valid    (bv_l),
    .busy         (busy_l),
    .words_sent   (words_l)
  );

  // ------------------------------------------------------- clock / watchdog
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before 2ms");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------- checker
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ------------------------------------------------------------- scoreboard
  always @(negedge clock) begin
    if (mon_en) begin
      check("busy_eq_bv_m", busy_m, bv_m);
      check("busy_eq_bv_l", busy_l, bv_l);
      if (bv_m) begin
        check("bit_expected_m", exp_m.size() != 0, 1);
        if (exp_m.size() != 0) check("bit_m", seq_m, exp_m.pop_front());
      end else begin
        check("idle_line_m", seq_m, 0);
        check("gap_m", exp_m.size(), 0);
      end
      if (bv_l) begin
        check("bit_expected_l", exp_l.size() != 0, 1);
        if (exp_l.size() != 0) check("bit_l", seq_l, exp_l.pop_front());
      end else begin
        check("idle_line_l", seq_l, 0);
        check("gap_l", exp_l.size(), 0);
      end
    end
  end

  // ---------------------------------------------------------- driver tasks
  // Called just after a negedge. Offers w until accepted; exp_wait >= 0 checks
  // how many cycles data_ready stayed low first. Returns just after the
  // negedge of the first bit cycle.
  task automatic send_word(input logic [W-1:0] w, input bit hold, input int exp_wait);
    int n;
    data_in    = w;
    data_valid = 1'b1;
    n = 0;
    while (!ready_m && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("accept_timeout", n < 100, 1);
    check("ready_agree", ready_l, ready_m);
    if (exp_wait >= 0) check("ready_wait", n, exp_wait);
    @(posedge clock);
    for (int i = W - 1; i >= 0; i--) exp_m.push_back(w[i]);
    for (int i = 0; i < W; i++) exp_l.push_back(w[i]);
    #1;
    if (!hold) data_valid = 1'b0;
    @(negedge clock);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy_m && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("idle_timeout", n < 50, 1);
  endtask

  // -------------------------------------------------------------- stimulus
  initial begin
    n_vec      = 0;
    n_err      = 0;
    mon_en     = 1'b0;
    reset      = 1'b1;
    data_valid = 1'b0;
    data_in    = '0;

    // Reset values
    repeat (2) @(negedge clock);
    check("rst_seq", seq_m, 0);
    check("rst_bv", bv_m, 0);
    check("rst_busy", busy_m, 0);
    check("rst_ready_m", ready_m, 0);
    check("rst_ready_l", ready_l, 0);
    check("rst_words", words_m, 16'h0000);
    reset  = 1'b0;
    mon_en = 1'b1;
    @(negedge clock);
    check("ready_after_rst", ready_m, 1);

    // Single word, idle afterwards
    send_word(8'hB8, 1'b0, 0);
    wait_idle();
    check("words_b8_m", words_m, 16'd1);
    check("words_b8_l", words_l, 16'd1);
    repeat (2) @(negedge clock);

    // Back-to-back stream: ready must stay low for exactly 7 bit cycles
    send_word(8'hA5, 1'b1, 0);
    send_word(8'h3C, 1'b0, 7);
    wait_idle();
    check("words_stream", words_m, 16'd3);

    // Order test pattern
    send_word(8'h1D, 1'b0, 0);
    wait_idle();
    check("words_1d", words_l, 16'd4);

    // data_valid pulse in mid-word is ignored
    send_word(8'h5A, 1'b0, 0);
    repeat (3) @(negedge clock);
    check("mid_ready_m", ready_m, 0);
    check("mid_ready_l", ready_l, 0);
    data_in    = 8'hFF;
    data_valid = 1'b1;
    @(negedge clock);
    data_valid = 1'b0;
    data_in    = '0;
    wait_idle();
    check("words_mid", words_m, 16'd5);
    @(negedge clock);
    check("mid_idle_bv", bv_m, 0);

    // Reset in the middle of a word
    send_word(8'hF0, 1'b0, 0);
    repeat (4) @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    exp_m.delete();
    exp_l.delete();
    @(negedge clock);
    check("midrst_seq_m", seq_m, 0);
    check("midrst_seq_l", seq_l, 0);
    check("midrst_bv", bv_m, 0);
    check("midrst_words", words_m, 16'd0);
    check("midrst_ready", ready_m, 0);
    reset = 1'b0;
    @(negedge clock);
    check("postrst_ready", ready_m, 1);
    send_word(8'h81, 1'b0, 0);
    wait_idle();
    check("words_81", words_m, 16'd1);

    // Counter wrap: preload both counters to FFFF, then send one word
    @(negedge clock);
    force dut_m.words_q = 16'hFFFF;
    force dut_l.words_q = 16'hFFFF;
    @(posedge clock);
    @(negedge clock);
    release dut_m.words_q;
    release dut_l.words_q;
    @(negedge clock);
    send_word(8'hC3, 1'b0, 0);
    wait_idle();
    check("wrap_m", words_m, 16'h0000);
    check("wrap_l", words_l, 16'h0000);

    repeat (3) @(negedge clock);
    check("drain_m", exp_m.size(), 0);
    check("drain_l", exp_l.size(), 0);
    mon_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/iiitb_sd_serializer.md
# iiitb_sd_serializer

Parallel-to-serial front end for the sequence detector: accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on a serial line that drives the detector's `sequence_in`. Back-to-back words stream without a bubble. While no word is pending, the line drives a fixed idle level of 0.

## Interface

- `WIDTH`, default 8: bits per word; legal range 2..32.
- `MSB_FIRST`, default 1: 1 sends bit WIDTH-1 first; 0 sends bit 0 first.
- `clock`  input  1  clock; all state changes on the rising edge.
- `reset`  input  1  synchronous, active-high reset; sampled on the rising edge of `clock`.
- `data_in`  input  WIDTH  parallel word to serialize.
- `data_valid`  input  1  `data_in` is valid this cycle.
- `data_ready`  output  1  block accepts `data_in` this cycle; transfer happens when `data_valid && data_ready` at a rising edge.
- `sequence_out`  output  1  serial bit stream; connects to the detector's `sequence_in`.
- `bit_valid`  output  1  high while `sequence_out` carries a payload bit.
- `busy`  output  1  high while in SHIFT.
- `words_sent`  output  16  count of fully transmitted words; wraps 0xFFFF -> 0x0000.

## Operation

- State machine, 2 states, encoded IDLE=1'b0 and SHIFT=1'b1.
- Internal state:
  - shift register `sreg[WIDTH-1:0]`.
  - bit index `cnt`, width clog2(WIDTH), counting 0..WIDTH-1.
- IDLE:
  - `data_ready`=1, `sequence_out`=0, `bit_valid`=0.
  - On accept: load `sreg`=`data_in`, `cnt`=0, go to SHIFT.
- SHIFT:
  - `sequence_out` = `sreg[WIDTH-1]` if MSB_FIRST, else `sreg[0]`. It is a registered output, taken straight from the flop.
  - `bit_valid`=1.
  - Each edge: shift `sreg` toward the output end and increment `cnt`.
- Last bit (SHIFT and `cnt`==WIDTH-1):
  - `data_ready`=1.
  - `words_sent` increments on this edge.
  - If a word is accepted on this edge: reload `sreg`, set `cnt`=0, stay in SHIFT. This is seamless streaming with no idle bit.
  - Otherwise go to IDLE; `sequence_out` returns to 0 on the next cycle.
- All other SHIFT cycles: `data_ready`=0. `data_valid` is ignored, and `data_in` does not need to be held stable.
- `data_ready` is a combinational function of state and `cnt` only. It never depends on `data_valid`, so there is no combinational loop.
- Reset (synchronous, overrides everything, including mid-word):
  - state=IDLE, `sreg`=0, `cnt`=0, `words_sent`=0.
  - Any partially sent word is discarded and is not counted.
  - `data_ready` is forced to 0 during any cycle in which `reset` is high.
- Reset values of outputs: `sequence_out`=0, `bit_valid`=0, `busy`=0, `words_sent`=0, `data_ready`=0 while reset is high, and 1 on the first cycle after release.

## Timing

- Word accepted at edge k:
  - first bit appears on `sequence_out` during cycle k+1 (after edge k).
  - bit j (in send order) appears during cycle k+1+j.
  - last bit appears during cycle k+WIDTH.
- Latency from accept to first bit: 1 cycle.
- Throughput: one word per WIDTH cycles when `data_valid` is held high; 100% line utilisation.
- Idle gap: if no word is offered at the last-bit edge, `sequence_out`=0 and `bit_valid`=0 from cycle k+WIDTH+1 until 1 cycle after the next accept.
- `words_sent` updates at the edge that ends the last bit; it is visible in cycle k+WIDTH+1.
- `busy` equals `bit_valid`.

## Test plan

- Reset, then word 8'hB8 (MSB_FIRST=1) -> `sequence_out` = 1,0,1,1,1,0,0,0 in cycles 1..8 after accept. With the detector attached, `detector_out` is 1 for exactly one cycle. `words_sent`=1.
- `data_valid` held high with words 8'hA5 then 8'h3C -> 16 consecutive bits 10100101_00111100 with `bit_valid` continuously 1. `data_ready` pulses only at the cycle-8 and cycle-16 bits. `words_sent`=2.
- MSB_FIRST=0, word 8'h1D -> bits 1,0,1,1,1,0,0,0 (LSB first).
- `data_valid` pulsed while in mid-SHIFT (cnt=3) with 8'hFF -> word ignored; the current word completes unaltered, then the line goes idle at 0.
- `reset` asserted at cnt=4 of word 8'hF0 -> on the next cycle `sequence_out`=0, `bit_valid`=0, `words_sent`=0. After release, `data_ready`=1 and a new 8'h81 is sent cleanly as 1,0,0,0,0,0,0,1.
- Start with `words_sent` at 16'hFFFF by sending 65535 words, then send 1 more -> `words_sent`=16'h0000, and no other output is disturbed.
